// File: rtl/cart_loader.sv
// cart_loader: converts the HPS upload byte stream into registered write
// strobes for cart bank 1, cart bank 2 and ext RAM. After a load it zero-clears
// the VRAM planes, then holds the CPU in reset for RESET_HOLD cycles.
//
// Ports:
//   clk, reset_n            system clock, async active-low reset
//   upload, upload_index    download-active level and image type
//   upload_wr/addr/data     one-cycle byte write from HPS
//   cart1_we, cart2_we,
//   ext_we, mem_addr,
//   mem_data                registered memory write port (1-cycle latency)
//   vram_clr_we/addr        VRAM zero-clear sequencer
//   cpu_reset, busy         high in any state other than IDLE
//   loaded_len              highest accepted address + 1
//   ext_used, overflow      ext RAM written / bytes >= C000h dropped
module cart_loader #(
  parameter int unsigned CART_INDEX = 1,
  parameter int unsigned RESET_HOLD = 16,
  parameter int unsigned VRAM_AW    = 13
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               upload,
  input  logic [7:0]         upload_index,
  input  logic               upload_wr,
  input  logic [24:0]        upload_addr,
  input  logic [7:0]         upload_data,
  output logic               cart1_we,
  output logic               cart2_we,
  output logic               ext_we,
  output logic [14:0]        mem_addr,
  output logic [7:0]         mem_data,
  output logic               vram_clr_we,
  output logic [VRAM_AW-1:0] vram_clr_addr,
  output logic               cpu_reset,
  output logic               busy,
  output logic [16:0]        loaded_len,
  output logic               ext_used,
  output logic               overflow
);

  localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [24:0] BANK2_BASE = 25'h0002000;
  localparam logic [24:0] EXT_BASE   = 25'h0004000;
  localparam logic [24:0] EXT_END    = 25'h000C000;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CLEAR, S_HOLD} state_t;

  state_t              r_state, w_state_nx;
  logic                r_upload_q;
  logic                r_cart1_we, r_cart2_we, r_ext_we;
  logic [14:0]         r_mem_addr;
  logic [7:0]          r_mem_data;
  logic                r_clr_we;
  logic [VRAM_AW-1:0]  r_clr_addr;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_active;
  logic [16:0]         r_len;
  logic                r_ext_used, r_ovf;

  logic                w_cart1_nx, w_cart2_nx, w_ext_nx;
  logic [14:0]         w_mem_addr_nx;
  logic [7:0]          w_mem_data_nx;
  logic [VRAM_AW-1:0]  w_clr_addr_nx;
  logic [HOLD_W-1:0]   w_hold_nx;
  logic [16:0]         w_len_nx;
  logic                w_ext_used_nx, w_ovf_nx;
  logic                w_match, w_start_edge;
  logic [16:0]         w_addr_p1;

  assign w_match      = upload && (upload_index == 8'(CART_INDEX));
  // Restart from CLEAR/HOLD only on a fresh upload, not a lingering level.
  assign w_start_edge = w_match && !r_upload_q;
  assign w_addr_p1    = upload_addr[16:0] + 17'd1;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_upload_q <= 1'b0;
      r_cart1_we <= 1'b0;
      r_cart2_we <= 1'b0;
      r_ext_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_clr_we   <= 1'b0;
      r_clr_addr <= '0;
      r_hold     <= '0;
      r_active   <= 1'b0;
      r_len      <= '0;
      r_ext_used <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_upload_q <= upload;
      r_cart1_we <= w_cart1_nx;
      r_cart2_we <= w_cart2_nx;
      r_ext_we   <= w_ext_nx;
      r_mem_addr <= w_mem_addr_nx;
      r_mem_data <= w_mem_data_nx;
      r_clr_we   <= (w_state_nx == S_CLEAR);
      r_clr_addr <= w_clr_addr_nx;
      r_hold     <= w_hold_nx;
      r_active   <= (w_state_nx != S_IDLE);
      r_len      <= w_len_nx;
      r_ext_used <= w_ext_used_nx;
      r_ovf      <= w_ovf_nx;
    end
  end

  // Next-state, write decode, clear and hold sequencing
  always_comb begin
    w_state_nx    = r_state;
    w_cart1_nx    = 1'b0;
    w_cart2_nx    = 1'b0;
    w_ext_nx      = 1'b0;
    w_mem_addr_nx = r_mem_addr;
    w_mem_data_nx = r_mem_data;
    w_clr_addr_nx = r_clr_addr;
    w_hold_nx     = r_hold;
    w_len_nx      = r_len;
    w_ext_used_nx = r_ext_used;
    w_ovf_nx      = r_ovf;

    case (r_state)
      S_IDLE: begin
        if (w_match) begin
          w_state_nx    = S_LOAD;
          w_len_nx      = '0;
          w_ext_used_nx = 1'b0;
          w_ovf_nx      = 1'b0;
        end
      end
      S_LOAD: begin
        if (!w_match) begin
          w_state_nx    = S_CLEAR;
          w_clr_addr_nx = '0;
        end else if (upload_wr) begin
          if (upload_addr < EXT_END) begin
            w_mem_data_nx = upload_data;
            if (w_addr_p1 > r_len) w_len_nx = w_addr_p1;
            if (upload_addr < BANK2_BASE) begin
              w_cart1_nx    = 1'b1;
              w_mem_addr_nx = {2'b00, upload_addr[12:0]};
            end else if (upload_addr < EXT_BASE) begin
              w_cart2_nx    = 1'b1;
              w_mem_addr_nx = {2'b00, upload_addr[12:0]};
            end else begin
              w_ext_nx      = 1'b1;
              w_ext_used_nx = 1'b1;
              w_mem_addr_nx = 15'(upload_addr - EXT_BASE);
            end
          end else begin
            w_ovf_nx = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (w_start_edge) begin
          w_state_nx    = S_LOAD;
          w_len_nx      = '0;
          w_ext_used_nx = 1'b0;
          w_ovf_nx      = 1'b0;
        end else if (r_clr_addr == '1) begin
          w_state_nx = S_HOLD;
          w_hold_nx  = HOLD_W'(RESET_HOLD - 1);
        end else begin
          w_clr_addr_nx = r_clr_addr + 1'b1;
        end
      end
      S_HOLD: begin
        if (w_start_edge) begin
          w_state_nx    = S_LOAD;
          w_len_nx      = '0;
          w_ext_used_nx = 1'b0;
          w_ovf_nx      = 1'b0;
        end else if (r_hold == '0) begin
          w_state_nx = S_IDLE;
        end else begin
          w_hold_nx = r_hold - 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign cart1_we      = r_cart1_we;
  assign cart2_we      = r_cart2_we;
  assign ext_we        = r_ext_we;
  assign mem_addr      = r_mem_addr;
  assign mem_data      = r_mem_data;
  assign vram_clr_we   = r_clr_we;
  assign vram_clr_addr = r_clr_addr;
  assign cpu_reset     = r_active;
  assign busy          = r_active;
  assign loaded_len    = r_len;
  assign ext_used      = r_ext_used;
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: table of upload writes with expected strobes,
// plus hand-written sequences for the VRAM clear, hold, restart and reset.
module tb_cart_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        upload;
  logic [7:0]  upload_index;
  logic        upload_wr;
  logic [24:0] upload_addr;
  logic [7:0]  upload_data;
  logic        cart1_we, cart2_we, ext_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data;
  logic        vram_clr_we;
  logic [12:0] vram_clr_addr;
  logic        cpu_reset, busy;
  logic [16:0] loaded_len;
  logic        ext_used, overflow;

  int n_pass  = 0;
  int n_total = 0;

  cart_loader #(.CART_INDEX(1), .RESET_HOLD(16), .VRAM_AW(13)) dut (
    .clk(clk), .reset_n(reset_n), .upload(upload), .upload_index(upload_index),
    .upload_wr(upload_wr), .upload_addr(upload_addr), .upload_data(upload_data),
    .cart1_we(cart1_we), .cart2_we(cart2_we), .ext_we(ext_we),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .vram_clr_we(vram_clr_we), .vram_clr_addr(vram_clr_addr),
    .cpu_reset(cpu_reset), .busy(busy), .loaded_len(loaded_len),
    .ext_used(ext_used), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        c1, c2, ex;
    logic [14:0] maddr;
    logic [7:0]  mdata;
    logic [16:0] len;
    logic        eused, ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    upload_wr   = 1'b1;
    upload_addr = a;
    upload_data = d;
    tick();
    upload_wr = 1'b0;
  endtask

  task automatic chk_strobes_low(input string name);
    chk(name, {29'd0, cart1_we, cart2_we, ext_we}, 32'd0);
  endtask

  initial begin
    int n, bad, h;
    vecs[0] = '{25'h0000000, 8'hAA, 1'b1, 1'b0, 1'b0, 15'h0000, 8'hAA, 17'h02000 - 17'h01FFF, 1'b0, 1'b0};
    vecs[1] = '{25'h0000001, 8'h55, 1'b1, 1'b0, 1'b0, 15'h0001, 8'h55, 17'h00002, 1'b0, 1'b0};
    vecs[2] = '{25'h0001FFF, 8'h0F, 1'b1, 1'b0, 1'b0, 15'h1FFF, 8'h0F, 17'h02000, 1'b0, 1'b0};
    vecs[3] = '{25'h0002000, 8'h11, 1'b0, 1'b1, 1'b0, 15'h0000, 8'h11, 17'h02001, 1'b0, 1'b0};
    vecs[4] = '{25'h0004000, 8'h22, 1'b0, 1'b0, 1'b1, 15'h0000, 8'h22, 17'h04001, 1'b1, 1'b0};
    vecs[5] = '{25'h0007FFF, 8'h33, 1'b0, 1'b0, 1'b1, 15'h3FFF, 8'h33, 17'h08000, 1'b1, 1'b0};
    vecs[6] = '{25'h000C000, 8'h44, 1'b0, 1'b0, 1'b0, 15'h3FFF, 8'h33, 17'h08000, 1'b1, 1'b1};

    reset_n = 1'b0; upload = 1'b0; upload_index = 8'd0;
    upload_wr = 1'b0; upload_addr = '0; upload_data = '0;
    #12;
    chk("rst_strobes", {29'd0, cart1_we, cart2_we, ext_we}, 32'd0);
    chk("rst_busy_cpu", {30'd0, busy, cpu_reset}, 32'd0);
    chk("rst_clr", {18'd0, vram_clr_we, vram_clr_addr}, 32'd0);
    chk("rst_len_flags", {13'd0, loaded_len, ext_used, overflow}, 32'd0);
    chk("rst_mem", {9'd0, mem_addr, mem_data}, 32'd0);
    #11 reset_n = 1'b1;
    tick();

    // Non-matching index is ignored
    upload = 1'b1; upload_index = 8'd0;
    tick();
    wr_byte(25'h0000010, 8'h99);
    chk_strobes_low("idx0_strobes");
    chk("idx0_busy", 32'(busy), 32'd0);
    tick();
    chk("idx0_busy2", 32'(busy), 32'd0);
    upload = 1'b0;
    tick();

    // Matching load
    upload = 1'b1; upload_index = 8'd1;
    tick();
    chk("load_busy", {30'd0, busy, cpu_reset}, 32'd3);
    chk("load_len0", 32'(loaded_len), 32'd0);
    for (int i = 0; i < 7; i++) begin
      wr_byte(vecs[i].addr, vecs[i].data);
      chk($sformatf("v%0d_strobes", i), {29'd0, cart1_we, cart2_we, ext_we},
          {29'd0, vecs[i].c1, vecs[i].c2, vecs[i].ex});
      chk($sformatf("v%0d_mem", i), {9'd0, mem_addr, mem_data}, {9'd0, vecs[i].maddr, vecs[i].mdata});
      chk($sformatf("v%0d_len", i), 32'(loaded_len), 32'(vecs[i].len));
      chk($sformatf("v%0d_flags", i), {30'd0, ext_used, overflow}, {30'd0, vecs[i].eused, vecs[i].ovf});
      tick();
      chk_strobes_low($sformatf("v%0d_pulse_width", i));
    end

    // Upload ends: full clear then hold
    upload = 1'b0;
    tick();
    n = 0; bad = 0;
    while (vram_clr_we === 1'b1 && n < 9000) begin
      if (vram_clr_addr !== 13'(n) || cpu_reset !== 1'b1) bad++;
      n++;
      tick();
    end
    chk("clr_count", n, 8192);
    chk("clr_addr_seq", bad, 0);
    h = 0; bad = 0;
    while (cpu_reset === 1'b1 && h < 100) begin
      if (busy !== 1'b1 || vram_clr_we !== 1'b0) bad++;
      h++;
      tick();
    end
    chk("hold_count", h, 16);
    chk("hold_busy", bad, 0);
    chk("idle_busy_cpu", {30'd0, busy, cpu_reset}, 32'd0);

    // Second load, then restart mid-clear
    upload = 1'b1;
    tick();
    chk("l2_len_cleared", {13'd0, loaded_len, ext_used, overflow}, 32'd0);
    wr_byte(25'h0005000, 8'h5A);
    chk("l2_ext", {29'd0, cart1_we, cart2_we, ext_we}, 32'd1);
    chk("l2_ext_addr", 32'(mem_addr), 32'h1000);
    wr_byte(25'h0000100, 8'h01);
    chk("l2_ooo_len", 32'(loaded_len), 32'h5001);
    wr_byte(25'h000C123, 8'h02);
    chk("l2_ovf", {30'd0, ext_used, overflow}, 32'd3);
    upload = 1'b0;
    tick();
    n = 0;
    while (vram_clr_addr !== 13'h0100 && n < 1000) begin
      n++;
      tick();
    end
    chk("l2_reach_100", 32'(vram_clr_addr), 32'h100);
    upload = 1'b1;
    tick();
    chk("rs_clr_we", 32'(vram_clr_we), 32'd0);
    chk("rs_busy_cpu", {30'd0, busy, cpu_reset}, 32'd3);
    chk("rs_cleared", {13'd0, loaded_len, ext_used, overflow}, 32'd0);
    tick();
    chk("rs_clr_we2", 32'(vram_clr_we), 32'd0);
    wr_byte(25'h0000010, 8'h77);
    chk("rs_cart1", {29'd0, cart1_we, cart2_we, ext_we}, 32'd4);
    chk("rs_len", 32'(loaded_len), 32'h11);
    upload = 1'b0;
    tick();
    chk("rs_clr_restart", {18'd0, vram_clr_we, vram_clr_addr}, {18'd0, 1'b1, 13'h0000});
    tick();
    tick();
    chk("rs_clr_addr2", 32'(vram_clr_addr), 32'd2);

    // Asynchronous reset mid-clear
    #3 reset_n = 1'b0;
    #1;
    chk("arst_clr", {18'd0, vram_clr_we, vram_clr_addr}, 32'd0);
    chk("arst_busy_cpu", {30'd0, busy, cpu_reset}, 32'd0);
    chk("arst_len_flags", {13'd0, loaded_len, ext_used, overflow}, 32'd0);
    chk("arst_mem", {9'd0, mem_addr, mem_data}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
